// File: rtl/echo_buffered.sv
// Receive-to-transmit echo path with a circular byte FIFO, optional
// upper-case folding and CR->CRLF expansion, and an overflow counter.
module echo_buffered #(
    parameter int DEPTH_LOG2 = 4,
    parameter bit UPPER      = 1'b0,
    parameter bit CRLF       = 1'b1,
    parameter int STAT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    input  logic                  tx_ready,
    output logic                  out_valid,
    output logic [7:0]            out_byte,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  empty,
    output logic                  full,
    output logic [STAT_WIDTH-1:0] overflow_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_F = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr, wptr1;
    state_t                state, state_nx;
    logic [7:0]            b;
    logic                  is_cr, push, drop, pop;
    logic [DEPTH_LOG2:0]   room, push_n, pop_n;

    assign empty = (fill == '0);
    assign full  = (fill == DEPTH_F);
    assign wptr1 = wptr + 1'b1;

    always_comb begin
        b = in_byte;
        if (UPPER && in_byte >= 8'h61 && in_byte <= 8'h7A)
            b = in_byte - 8'h20;
        is_cr = CRLF && (b == 8'h0D);
        // Space check uses start-of-cycle occupancy; a same-cycle pop never helps.
        room = DEPTH_F - fill;
        push = in_valid && (is_cr ? (room >= (DEPTH_LOG2+1)'(2))
                                  : (room >= (DEPTH_LOG2+1)'(1)));
        drop = in_valid && !push;
        push_n = '0;
        if (push)
            push_n = is_cr ? (DEPTH_LOG2+1)'(2) : (DEPTH_LOG2+1)'(1);
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && tx_ready) begin
                    pop      = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND:    state_nx = HOLD;
            HOLD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        pop_n = pop ? (DEPTH_LOG2+1)'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            if (is_cr) begin
                mem[wptr]  <= 8'h0D;
                mem[wptr1] <= 8'h0A;
            end else begin
                mem[wptr] <= b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wptr           <= '0;
            rptr           <= '0;
            fill           <= '0;
            out_valid      <= 1'b0;
            out_byte       <= 8'h00;
            overflow_count <= '0;
        end else begin
            state     <= state_nx;
            out_valid <= pop;
            fill      <= fill + push_n - pop_n;
            if (pop) begin
                out_byte <= mem[rptr];
                rptr     <= rptr + 1'b1;
            end
            if (push)
                wptr <= wptr + DEPTH_LOG2'(push_n);
            if (drop && overflow_count != '1)
                overflow_count <= overflow_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_echo_buffered.sv
// Self-checking bench for echo_buffered: directed steps plus random traffic
// compared every cycle against a queue-based reference model.
module tb_echo_buffered;

    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int SW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          tx_ready = 1'b0;
    logic          out_valid;
    logic [7:0]    out_byte;
    logic [DL:0]   fill;
    logic          empty;
    logic          full;
    logic [SW-1:0] overflow_count;

    always #5 clk = ~clk;

    echo_buffered #(
        .DEPTH_LOG2(DL),
        .UPPER(1'b1),
        .CRLF(1'b1),
        .STAT_WIDTH(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_byte(in_byte),
        .tx_ready(tx_ready),
        .out_valid(out_valid),
        .out_byte(out_byte),
        .fill(fill),
        .empty(empty),
        .full(full),
        .overflow_count(overflow_count)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queue of pending bytes, cooldown after each issue.
    byte unsigned q[$];
    int           ovf  = 0;
    int           cool = 0;
    logic [7:0]   last = 8'h00;
    logic         exp_v = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovf   = 0;
        cool  = 0;
        last  = 8'h00;
        exp_v = 1'b0;
    endtask

    task automatic model_edge();
        int           old;
        int           need;
        byte unsigned b;
        old   = q.size();
        exp_v = 1'b0;
        if (cool > 0) begin
            cool--;
        end else if (tx_ready && old > 0) begin
            last  = q.pop_front();
            exp_v = 1'b1;
            cool  = 2;
        end
        if (in_valid) begin
            b = in_byte;
            if (b >= 8'h61 && b <= 8'h7A)
                b = b - 8'd32;
            need = (b == 8'h0D) ? 2 : 1;
            if (old + need <= DEPTH) begin
                q.push_back(b);
                if (need == 2)
                    q.push_back(8'h0A);
            end else if (ovf < 255) begin
                ovf++;
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r);
        in_valid = v;
        in_byte  = d;
        tx_ready = r;
        @(posedge clk);
        model_edge();
        #1;
        chk("fill", 32'(fill), q.size());
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        if (exp_v)
            chk("out_byte", 32'(out_byte), 32'(last));
        chk("overflow", 32'(overflow_count), ovf);
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && q.size() > 0; i++)
            step(1'b0, 8'h00, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk("drain_empty", 32'(empty), 1);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_fill", 32'(fill), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_byte", 32'(out_byte), 0);
        chk("rst_ovf", 32'(overflow_count), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single byte, latency N+2
        step(1'b1, 8'h41, 1'b1);
        chk("lat_n1", 32'(out_valid), 0);
        step(1'b0, 8'h00, 1'b1);
        chk("lat_n2", 32'(out_valid), 1);
        chk("lat_byte", 32'(out_byte), 32'h41);
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Fill to full, overflow, drain in order
        for (int i = 0; i < 16; i++)
            step(1'b1, 8'(8'h31 + i), 1'b0);
        chk("full16", 32'(full), 1);
        step(1'b1, 8'h58, 1'b0);
        chk("ovf1", 32'(overflow_count), 1);
        drain(100);

        // CR needs two slots
        for (int i = 0; i < 15; i++)
            step(1'b1, 8'($urandom_range(8'h20, 8'h7E)), 1'b0);
        step(1'b1, 8'h0D, 1'b0);
        chk("cr_drop_fill", 32'(fill), 15);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h0D, 1'b0);
        chk("cr_fill16", 32'(fill), 16);
        drain(100);
        chk("crlf_tail", 32'(out_byte), 32'h0A);

        // Upper-case folding
        step(1'b1, 8'h61, 1'b0);
        step(1'b1, 8'h7A, 1'b0);
        step(1'b1, 8'h7B, 1'b0);
        step(1'b1, 8'h40, 1'b0);
        drain(40);
        chk("upper_tail", 32'(out_byte), 32'h40);

        // Random traffic around half full
        for (int i = 0; i < 8; i++)
            step(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 2) == 0, 8'($urandom),
                 $urandom_range(0, 9) != 0);
        drain(100);

        // Saturation, then async reset during SEND
        for (int i = 0; i < 16; i++)
            step(1'b1, 8'($urandom_range(8'h20, 8'h7E)), 1'b0);
        for (int i = 0; i < 300; i++)
            step(1'b1, 8'($urandom), 1'b0);
        chk("sat", 32'(overflow_count), 32'hFF);
        step(1'b0, 8'h00, 1'b1);
        chk("send_valid", 32'(out_valid), 1);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_fill", 32'(fill), 0);
        chk("arst_ovf", 32'(overflow_count), 0);
        chk("arst_empty", 32'(empty), 1);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h62, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_byte", 32'(out_byte), 32'h42);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/echo_buffered.md
Name: echo_buffered

Overview:
- Parametrised successor to the unbuffered echo path. Sits between the uart_receiver byte interface and the uart_transmitter byte interface.
- Received bytes go into a circular FIFO, so bytes that arrive while the transmitter is busy are queued rather than dropped.
- Optional per-byte transforms: lower-to-upper case folding, and CR to CR LF expansion.
- Counts bytes lost to a full FIFO.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth 2^DEPTH_LOG2, minimum 1 i.e. 2 entries).
- UPPER, 0, 1 folds ASCII 0x61-0x7A to 0x41-0x5A at push.
- CRLF, 1, 1 expands each received 0x0D into two FIFO entries, 0x0D then 0x0A.
- STAT_WIDTH, 8, width of the overflow counter.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  one-cycle pulse: in_byte valid (driven by receiver tx_new_byte).
- in_byte  input  8  received byte.
- tx_ready  input  1  transmitter idle, can accept a byte.
- out_valid  output  1  one-cycle pulse to transmitter rx_new_byte.
- out_byte  output  8  byte to transmitter rx_byte, held stable until next out_valid.
- fill  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.
- empty  output  1  fill == 0.
- full  output  1  fill == 2^DEPTH_LOG2.
- overflow_count  output  STAT_WIDTH  number of dropped input events, saturating.

Behaviour:
- Reset (async assert, sync release by clk): the following clear immediately:
  - write pointer, read pointer, fill;
  - out_valid, out_byte, overflow_count (all 0);
  - empty=1, full=0;
  - output FSM to IDLE.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. fill is tracked separately; full and empty derive from fill.
- Push, on a cycle with in_valid=1:
  - Byte b is in_byte, folded to upper case if UPPER=1.
  - Case 1, CRLF=1 and b==0x0D: needs 2 free slots (fill <= depth-2). Writes 0x0D at wptr and 0x0A at wptr+1; wptr += 2; fill += 2.
  - Case 2, any other byte: needs 1 free slot. Writes b; wptr += 1; fill += 1.
  - Insufficient space: entire event dropped (no partial CR), overflow_count += 1, saturating at all-ones.
- Free-space check uses the occupancy at the start of the cycle. A same-cycle pop does not create space (no bypass).
- Output FSM, three states:
  - IDLE: if !empty and tx_ready, then on that edge register out_byte <= mem[rptr], out_valid <= 1, rptr += 1, fill -= 1, go to SEND.
  - SEND: out_valid <= 0, go to HOLD.
  - HOLD: one-cycle holdoff so tx_ready can deassert; go to IDLE.
  - Consequence: at most one byte issued per 3 cycles, and out_valid is never high on consecutive cycles.
- Latency: in_valid at cycle N into an empty FIFO with tx_ready high gives out_valid high in cycle N+2.
- Simultaneous push and pop: fill changes by (+1 or +2) - 1 in the same cycle. Data is never corrupted. The pop reads the entry written in an earlier cycle.
- tx_ready low: FSM stays in IDLE and the FIFO fills. Order is strictly FIFO, with no reordering or duplication.
- Reset mid-operation: FIFO contents are discarded (memory need not be cleared), counters are zeroed, and any pending out_valid is cancelled.
- Depth-2 configuration with CRLF=1: a CR is accepted only when the FIFO is empty.

Test Plan:
- Reset, then a single 0x41 with tx_ready=1 -> out_valid one cycle at N+2, out_byte=0x41, fill returns to 0, overflow_count=0.
- tx_ready=0, push 0x31..0x40 (16 bytes, DEPTH_LOG2=4) -> full=1, fill=16. A 17th byte 0x58 -> dropped, overflow_count=1. Raise tx_ready -> 0x31..0x40 emitted in order, one per 3 cycles, then empty=1.
- CRLF=1, push 0x0D with fill=15 -> dropped, overflow_count+1, fill stays 15. Drain to fill=14, push 0x0D -> fill=16; the last two bytes out are 0x0D, 0x0A.
- UPPER=1, push 0x61, 0x7A, 0x7B, 0x40 -> out 0x41, 0x5A, 0x7B, 0x40.
- Continuous in_valid every cycle while popping, fill near 8 -> fill tracks +1/-1 correctly, no lost or duplicated bytes versus a scoreboard.
- 200 overflow events with STAT_WIDTH=8, then more -> count saturates at 0xFF. Async rst pulse mid-SEND -> out_valid low immediately, fill=0, count=0.
